muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 32, operand width in bits; legal range is even values of 4 or more.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start_i, input, 1 bit: request to start an operation.
REQ-005 Port op_i, input, 2 bits: operation select; 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
REQ-006 Port a_i, input, DATA_W bits: multiplicand or dividend.
REQ-007 Port b_i, input, DATA_W bits: multiplier or divisor.
REQ-008 Port annul_i, input, 1 bit: pipeline flush; discards the operation in flight.
REQ-009 Port busy_o, output, 1 bit: unit occupied; the issue stage SHALL use it as the stall request.
REQ-010 Port valid_o, output, 1 bit: single-cycle pulse marking that hi_o/lo_o carry a new result.
REQ-011 Port hi_o, output, DATA_W bits: product high half, or remainder.
REQ-012 Port lo_o, output, DATA_W bits: product low half, or quotient.
REQ-013 Port div_zero_o, output, 1 bit: the last result came from a divide with b = 0.

Function
REQ-014 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-015 Accept: a start is accepted on an edge E0 where the state is IDLE, start_i = 1 and annul_i = 0; a_i, b_i and op_i SHALL be latched at E0.
REQ-016 Later changes to a_i, b_i and op_i SHALL be ignored until the next accept.
REQ-017 start_i SHALL be ignored in RUN and DONE, with no queuing.
REQ-018 Nonzero-divisor operations and all multiplies: IDLE goes to RUN at E0, with the iteration counter cleared to 0.
REQ-019 RUN SHALL perform one radix-2 iteration per cycle: shift-add for multiply, restoring subtract for divide.
REQ-020 After DATA_W iterations the state SHALL move to DONE, on edge E0+DATA_W.
REQ-021 valid_o SHALL be 1 only while the state is DONE, i.e. exactly one cycle; DONE goes to IDLE on the next edge.
REQ-022 Divide with b = 0: the state SHALL go IDLE to DONE at E0; valid_o is high in the cycle after E0.
REQ-023 Divide with b = 0 result: hi_o = the latched a, lo_o = all ones, div_zero_o = 1.
REQ-024 div_zero_o SHALL be 0 for every other result.
REQ-025 busy_o SHALL be 1 whenever the state is RUN or DONE.
REQ-026 Signed operations (MULT, DIV) SHALL compute on operand magnitudes.
REQ-027 For MULT, the 2*DATA_W product SHALL be negated when the operand signs differ.
REQ-028 For DIV, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-029 DIV of the most-negative value by -1 SHALL give quotient = most-negative value (wrap) and remainder = 0.
REQ-030 MULTU and DIVU SHALL treat operands as unsigned.
REQ-031 hi_o, lo_o and div_zero_o SHALL update only when entering DONE, and SHALL hold until the next DONE.
REQ-032 annul_i = 1 in RUN or DONE SHALL force IDLE on the next edge.
REQ-033 After an annul, valid_o SHALL be 0 and hi_o, lo_o and div_zero_o SHALL keep their prior values.
REQ-034 annul_i and start_i both high in IDLE: annul wins and the start is not accepted.
REQ-035 annul_i in DONE SHALL suppress nothing: valid_o is already being presented that cycle, and the state returns to IDLE.

Reset
REQ-036 rst = 1 SHALL, on the next edge, force the state to IDLE and clear the iteration counter.
REQ-037 rst = 1 SHALL, on the next edge, clear busy_o, valid_o, hi_o, lo_o and div_zero_o to 0.
REQ-038 rst SHALL take priority over start_i and annul_i.
REQ-039 Reset asserted mid-RUN SHALL abandon the operation with no valid_o pulse.

Verification (DATA_W = 32)
REQ-040 The bench SHALL cover MULTU with a = b = 0xFFFFFFFF: valid_o high exactly 32 edges after accept, hi_o = 0xFFFFFFFE, lo_o = 0x00000001, busy_o high for 33 cycles.
REQ-041 The bench SHALL cover MULT with -3 × 5: hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFF1.
REQ-042 The bench SHALL cover DIV -7 / 2 (lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF), then DIVU 7 / 2 (lo_o = 3, hi_o = 1).
REQ-043 The bench SHALL cover DIV 0x80000000 / 0xFFFFFFFF: lo_o = 0x80000000, hi_o = 0, div_zero_o = 0.
REQ-044 The bench SHALL cover DIVU 0x1234 / 0: valid_o in the cycle after accept, hi_o = 0x00001234, lo_o = 0xFFFFFFFF, div_zero_o = 1.
REQ-045 The bench SHALL cover annul_i pulsed at iteration 10: no valid_o, busy_o low after the next edge, prior hi_o/lo_o held.
REQ-046 The bench SHALL cover start_i held high during RUN: no second operation is accepted.
REQ-047 The bench SHALL cover rst mid-RUN: all outputs 0 on the next edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring division, one step per
//   cycle. Signed operations work on magnitudes and fix the signs at the end.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i, op_i  start request, op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a_i, b_i       multiplicand/dividend, multiplier/divisor
//   annul_i        flush, discards the operation in flight
//   busy_o         unit occupied (RUN or DONE)
//   valid_o        one-cycle pulse with a new result on hi_o/lo_o
//   hi_o, lo_o     product high/low half, or remainder/quotient
//   div_zero_o     last result came from a divide by zero
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_zero_o
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] work_hi;
  logic [DATA_W-1:0] work_lo;

  // Operand decode at the accept edge
  logic              accept;
  logic              signed_op;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;

  assign accept    = (state == IDLE) && start_i && !annul_i;
  assign signed_op = ~op_i[0];
  assign a_neg     = signed_op & a_i[DATA_W-1];
  assign b_neg     = signed_op & b_i[DATA_W-1];
  assign a_abs     = a_neg ? -a_i : a_i;
  assign b_abs     = b_neg ? -b_i : b_i;

  // One iteration step. work_lo holds the multiplier / remaining dividend
  // bits, work_hi the partial product / partial remainder.
  logic [DATA_W:0]     mul_sum;
  logic                div_ge;
  logic [DATA_W-1:0]   div_diff;
  logic [DATA_W-1:0]   step_hi;
  logic [DATA_W-1:0]   step_lo;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   fin_hi;
  logic [DATA_W-1:0]   fin_lo;

  assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_mag} : '0);
  // The partial remainder is always below the divisor, so the difference
  // fits in DATA_W bits whenever the trial subtraction succeeds.
  assign div_ge   = {work_hi, work_lo[DATA_W-1]} >= {1'b0, b_mag};
  assign div_diff = {work_hi[DATA_W-2:0], work_lo[DATA_W-1]} - b_mag;

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (is_div) begin
      step_hi = div_ge ? div_diff : {work_hi[DATA_W-2:0], work_lo[DATA_W-1]};
      step_lo = {work_lo[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], work_lo[DATA_W-1:1]};
    end
  end

  // Sign fix-up on the final step; most-negative / -1 wraps naturally.
  assign prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign quo_fix  = neg_q ? -step_lo : step_lo;
  assign rem_fix  = neg_r ? -step_hi : step_hi;
  assign fin_hi   = is_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
  assign fin_lo   = is_div ? quo_fix : prod_fix[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      b_mag      <= '0;
      work_hi    <= '0;
      work_lo    <= '0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (accept) begin
            busy_o  <= 1'b1;
            is_div  <= op_i[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            b_mag   <= b_abs;
            work_hi <= '0;
            work_lo <= a_abs;
            count   <= '0;
            if (op_i[1] && (b_i == '0)) begin
              // Divide by zero completes immediately
              state      <= DONE;
              valid_o    <= 1'b1;
              hi_o       <= a_i;
              lo_o       <= '1;
              div_zero_o <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            busy_o <= 1'b0;
          end
        end
        RUN: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            count   <= count + CW'(1);
            if (count == CW'(DATA_W - 1)) begin
              state      <= DONE;
              valid_o    <= 1'b1;
              hi_o       <= fin_hi;
              lo_o       <= fin_lo;
              div_zero_o <= 1'b0;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
